// File: rtl/snoopy_game_controller.sv
// Top-level sequencer for the Snoopy runner game: frame-rate tick divider,
// per-frame jump request queue, game-state machine and score keeping.
module snoopy_game_controller #(
    parameter int TICK_DIV       = 833333,
    parameter int SCORE_W        = 10,
    parameter int SCORE_EVERY    = 6,
    parameter int HIT_HOLD_TICKS = 30
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               key_jump,
    input  logic               key_start,
    input  logic               collision,
    output logic               frame_tick,
    output logic               jump_pulse,
    output logic               physics_en,
    output logic [1:0]         game_state,
    output logic               game_over,
    output logic [SCORE_W-1:0] score
);

    // +1 keeps the counter widths at least one bit when the limit is 1.
    localparam int TICK_W = $clog2(TICK_DIV);
    localparam int DIV_W  = $clog2(SCORE_EVERY + 1);
    localparam int HIT_W  = $clog2(HIT_HOLD_TICKS + 1);

    localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(TICK_DIV - 1);
    localparam logic [DIV_W-1:0]  SCORE_LAST = DIV_W'(SCORE_EVERY - 1);
    localparam logic [HIT_W-1:0]  HIT_LAST   = HIT_W'(HIT_HOLD_TICKS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_PLAY = 2'b01,
        S_HIT  = 2'b10,
        S_OVER = 2'b11
    } state_t;

    state_t             state, state_n;
    logic [TICK_W-1:0]  tick_cnt;
    logic [DIV_W-1:0]   score_div, score_div_n;
    logic [HIT_W-1:0]   hit_cnt, hit_cnt_n;
    logic [SCORE_W-1:0] score_n;
    logic               jump_pending, jump_pending_n;
    logic               jump_pulse_n;
    logic               key_jump_d, key_start_d;
    logic               tick_now, rise_j, rise_s;

    assign tick_now   = (tick_cnt == TICK_LAST);
    assign rise_j     = key_jump & ~key_jump_d;
    assign rise_s     = key_start & ~key_start_d;
    assign game_state = state;

    // State register, divider, key delay lines and registered outputs.
    always_ff @(posedge clock) begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge values, independent of statement order.
        if (reset) begin
            state        <= S_IDLE;
            tick_cnt     <= '0;
            score_div    <= '0;
            hit_cnt      <= '0;
            jump_pending <= 1'b0;
            jump_pulse   <= 1'b0;
            frame_tick   <= 1'b0;
            physics_en   <= 1'b0;
            game_over    <= 1'b0;
            score        <= '0;
            // Held keys must not look like a fresh press after reset.
            key_jump_d   <= 1'b1;
            key_start_d  <= 1'b1;
        end else begin
            state        <= state_n;
            tick_cnt     <= tick_now ? '0 : tick_cnt + 1'b1;
            score_div    <= score_div_n;
            hit_cnt      <= hit_cnt_n;
            jump_pending <= jump_pending_n;
            jump_pulse   <= jump_pulse_n;
            frame_tick   <= tick_now;
            physics_en   <= (state_n == S_PLAY);
            game_over    <= (state_n == S_OVER);
            score        <= score_n;
            key_jump_d   <= key_jump;
            key_start_d  <= key_start;
        end
    end

    // Next-state, jump queue, score and hit-hold counter.
    always_comb begin
        // NOTE: every target gets a default first so no path infers a latch.
        state_n        = state;
        score_n        = score;
        score_div_n    = score_div;
        hit_cnt_n      = hit_cnt;
        jump_pending_n = 1'b0;
        jump_pulse_n   = 1'b0;

        case (state)
            S_IDLE, S_OVER: begin
                if (rise_s) begin
                    state_n     = S_PLAY;
                    score_n     = '0;
                    score_div_n = '0;
                end
            end
            S_PLAY: begin
                // Collision wins over both the score update and the jump.
                if (collision) begin
                    state_n   = S_HIT;
                    hit_cnt_n = '0;
                end else if (tick_now) begin
                    jump_pulse_n = jump_pending | rise_j;
                    if (score_div == SCORE_LAST) begin
                        score_div_n = '0;
                        score_n     = (score == '1) ? score : score + 1'b1;
                    end else begin
                        score_div_n = score_div + 1'b1;
                    end
                end else begin
                    jump_pending_n = jump_pending | rise_j;
                end
            end
            S_HIT: begin
                if (tick_now) begin
                    if (hit_cnt == HIT_LAST) state_n = S_OVER;
                    else                     hit_cnt_n = hit_cnt + 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

endmodule

// File: doc/snoopy_game_controller.md
# snoopy_game_controller

Top-level sequencer for the Snoopy runner game. Generates the frame-rate physics tick, converts the raw jump key into one jump request per frame, and runs the game-state machine (idle, play, hit, over). It also keeps the score. Its outputs enable and drive the vertical-motion FSM and the horizontal and obstacle logic, and it consumes the collision flag from the collision checker.

## Interface
Parameters:
- TICK_DIV, 833333: clock cycles per frame tick (60 Hz at 50 MHz); minimum 2.
- SCORE_W, 10: score width in bits.
- SCORE_EVERY, 6: PLAY-state frame ticks per score increment; minimum 1.
- HIT_HOLD_TICKS, 30: frame ticks spent in HIT before OVER; minimum 1.

Ports:
- clock  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- key_jump  in  1  jump key level, already synchronised to clock.
- key_start  in  1  start/restart key level, already synchronised.
- collision  in  1  level from the collision checker; sampled every cycle.
- frame_tick  out  1  one-cycle pulse every TICK_DIV cycles; runs in all states.
- jump_pulse  out  1  one-cycle jump request; only ever coincident with frame_tick.
- physics_en  out  1  high only in PLAY; gates the motion FSMs.
- game_state  out  2  00 IDLE, 01 PLAY, 10 HIT, 11 OVER.
- game_over  out  1  high in OVER.
- score  out  SCORE_W  current score.

## Operation
- Reset (the clock edge with reset=1) sets:
  - tick_cnt=0, score_div=0, hit_cnt=0, jump_pending=0.
  - All outputs 0; game_state=IDLE.
  - key_jump_d=1 and key_start_d=1, so a key held through reset produces no edge.
- Edge detection:
  - rise_j = key_jump & ~key_jump_d.
  - rise_s = key_start & ~key_start_d.
  - Both delay registers update every cycle.
- Tick divider:
  - tick_cnt counts 0..TICK_DIV-1 and then wraps to 0.
  - Internal strobe tick_now = (tick_cnt == TICK_DIV-1).
  - frame_tick is registered: frame_tick <= tick_now.
- Jump queue (PLAY only):
  - Non-tick cycle: jump_pending <= jump_pending | rise_j.
  - tick_now cycle: jump_pulse <= jump_pending | rise_j, then jump_pending <= 0.
  - Several edges within one frame merge into a single pulse.
  - In any other state, jump_pending is forced to 0 and jump_pulse=0.
- State machine:
  - IDLE: on rise_s go to PLAY; clear score, score_div and jump_pending.
  - PLAY: on each tick_now, increment score_div. When score_div reaches SCORE_EVERY-1, wrap it to 0 and increment score, saturating at 2^SCORE_W-1. If collision=1 on any cycle, go to HIT and set hit_cnt=0.
  - HIT: physics_en=0. On each tick_now, increment hit_cnt. On the tick where hit_cnt reaches HIT_HOLD_TICKS-1, go to OVER.
  - OVER: score held; game_over=1. On rise_s go to PLAY and clear score, score_div and jump_pending.
- Priority in PLAY when events coincide: collision beats the score increment and the jump. On a cycle with collision=1 and tick_now=1: no score change, jump_pulse=0, jump_pending cleared.
- rise_s is ignored in PLAY and HIT. rise_j is ignored outside PLAY.
- Reset in any state or mid-frame returns every register to its reset value on that same edge.

## Timing
- All outputs are registered and change only on a clock edge.
- game_state, physics_en and game_over change on the edge that samples the triggering input, so they are visible one cycle after the input is presented.
- First frame_tick is high in the cycle after the edge at which tick_cnt=TICK_DIV-1, i.e. TICK_DIV cycles after reset deasserts. After that, the pulse period is exactly TICK_DIV cycles.
- jump_pulse and the score update are both committed on the tick_now edge, so they are visible together with frame_tick.
- A jump edge arriving in the same cycle as tick_now is serviced on that tick, not the next one.
- HIT lasts exactly HIT_HOLD_TICKS frame ticks; OVER is entered on the edge of the last one.

## Test plan
All scenarios use TICK_DIV=4, SCORE_EVERY=2, HIT_HOLD_TICKS=3, SCORE_W=4.
1. Reset with key_start held at 1, then release reset -> stays IDLE. frame_tick first high 4 cycles after reset deasserts, then every 4 cycles. A new key_start rise -> PLAY, physics_en=1 next cycle.
2. PLAY with 3 key_jump rising edges inside one frame -> exactly one jump_pulse, coincident with the next frame_tick. No pulse on the following tick unless a new edge arrives.
3. PLAY for 40 ticks with no collision -> score increments every 2nd tick and saturates at 15.
4. Collision asserted in the same cycle as tick_now with jump pending -> HIT next cycle. Score unchanged, jump_pulse=0, physics_en=0. OVER after exactly 3 further ticks, game_over=1.
5. In OVER, key_jump edges -> no jump_pulse. key_start rise -> PLAY with score=0.
6. Reset asserted mid-HIT, tick_cnt=2 -> next cycle: IDLE, all outputs 0, tick_cnt restarts from 0.
